// File: rtl/test_1_if.sv
// Channelizer sample stream feeding the AGC: one signed I/Q pair per strobe.
interface test_1_if #(
  parameter int W_IN = 16
);
  logic signed [W_IN-1:0] dataI;
  logic signed [W_IN-1:0] dataQ;
  logic                   valid;

  modport master (
    output dataI,
    output dataQ,
    output valid
  );

  modport slave (
    input dataI,
    input dataQ,
    input valid
  );
endinterface

// File: rtl/test_1.sv
// Digital AGC for a complex baseband channel.
// Each captured I/Q pair is scaled by the current gain (Q8.10). The scaled
// magnitude |yI|+|yQ| is smoothed by a first-order IIR. The gain is then
// nudged by the error between the reference level and the filtered amplitude.
// Pipeline, relative to the capture edge t:
//   t+1 scaled outputs, t+2 amplitude, t+3 filter, t+4 error, t+5 gain.
// Samples may arrive back to back. Each one carries its own loop controls
// down the pipe, and the shared P/G state updates in arrival order.
module test_1 #(
  parameter int W_IN        = 16,
  parameter int W_IN_MODULE = 26,
  parameter int BWIDTH      = 18,
  parameter int FILTERWIDTH = 13,
  parameter int AWIDTH      = 30,
  parameter int DWIDTH      = 27,
  parameter int RWIDTH      = 8,
  parameter int DSPWIDTH    = 48,
  parameter int W_OUT       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  test_1_if.slave                       s_chans,
  input  logic [FILTERWIDTH-1:0]        Filter_Coefficient,
  input  logic [FILTERWIDTH-1:0]        Error_Coefficient,
  input  logic [RWIDTH-1:0]             R_level,
  output logic                          Valid_Out,
  output logic signed [W_IN_MODULE-1:0] OutputI,
  output logic signed [W_IN_MODULE-1:0] OutputQ
);

  // Gain is Q8.10, so products shift right by 10 to return to sample units.
  localparam int G_FRAC   = 10;
  // The reference is expressed in units of 256 output LSBs.
  localparam int R_SHIFT  = 8;
  // The loop-gain product is scaled down by 2^19 before it touches G.
  localparam int E_SHIFT  = 19;

  // Datapath widths. Every product is sized exactly, with no guard bits.
  localparam int Y_PROD_W = W_IN + BWIDTH;                 // sample * gain
  localparam int P_DIFF_W = AWIDTH + 1;                    // A - P, signed
  localparam int P_PROD_W = P_DIFF_W + FILTERWIDTH + 1;    // (A - P) * Fc
  localparam int P_SUM_W  = P_PROD_W + 1;
  localparam int E_WIDE_W = AWIDTH + 1;                    // (R << 8) - P
  localparam int E_PROD_W = DWIDTH + FILTERWIDTH + 1;      // e * Ec
  localparam int G_SUM_W  = E_PROD_W + 1;

  localparam logic [BWIDTH-1:0] G_UNITY = BWIDTH'(1 << G_FRAC);
  localparam logic [BWIDTH-1:0] G_MAX   = {BWIDTH{1'b1}};
  localparam logic signed [G_SUM_W-1:0] G_SUM_MAX =
    {{(G_SUM_W - BWIDTH){1'b0}}, {BWIDTH{1'b1}}};

  // W_OUT is reserved. DSPWIDTH bounds the product widths chosen above.
  localparam int unused_w_out = W_OUT;
  localparam bit unused_dsp_fit = (Y_PROD_W <= DSPWIDTH) &&
                                  (P_PROD_W <= DSPWIDTH) &&
                                  (E_PROD_W <= DSPWIDTH);

  // vld_reg[k] marks a sample that completed stage k on the last edge.
  // Stage 0 is capture, 1 is scale, 2 is amplitude, 3 is filter, 4 is error.
  logic [4:0]             vld_reg;

  // Loop controls travel with their sample until the stage that needs them.
  logic [FILTERWIDTH-1:0] fc_reg [3];
  logic [FILTERWIDTH-1:0] ec_reg [5];
  logic [RWIDTH-1:0]      r_reg  [4];

  logic [BWIDTH-1:0]      g_reg;
  logic [BWIDTH-1:0]      g_next;
  logic [AWIDTH-1:0]      a_reg;
  logic [AWIDTH-1:0]      a_next;
  logic [AWIDTH-1:0]      p_reg;
  logic [AWIDTH-1:0]      p_next;
  logic signed [DWIDTH-1:0] e_reg;
  logic signed [DWIDTH-1:0] e_next;

  // Advance the pipeline valids. Reset discards every sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= {vld_reg[3:0], s_chans.valid};
    end
  end

  // Capture the controls on the strobe, then shift them alongside the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) fc_reg[k] <= '0;
      for (int k = 0; k < 5; k++) ec_reg[k] <= '0;
      for (int k = 0; k < 4; k++) r_reg[k]  <= '0;
    end else begin
      if (s_chans.valid) begin
        fc_reg[0] <= Filter_Coefficient;
        ec_reg[0] <= Error_Coefficient;
        r_reg[0]  <= R_level;
      end
      for (int k = 1; k < 3; k++) fc_reg[k] <= fc_reg[k-1];
      for (int k = 1; k < 5; k++) ec_reg[k] <= ec_reg[k-1];
      for (int k = 1; k < 4; k++) r_reg[k]  <= r_reg[k-1];
    end
  end

  // Identical scaling lanes: lane 0 is I and lane 1 is Q.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [W_IN-1:0]        din_in;
      logic signed [W_IN-1:0]        din_reg;
      logic signed [Y_PROD_W-1:0]    prod;
      logic signed [Y_PROD_W-1:0]    scaled;
      logic signed [W_IN_MODULE-1:0] y_next;
      logic signed [W_IN_MODULE-1:0] y_reg;
      logic signed [AWIDTH-1:0]      y_ext;
      logic [AWIDTH-1:0]             mag;

      assign din_in = (gi == 0) ? s_chans.dataI : s_chans.dataQ;

      // Gain is unsigned, so a zero is prepended before the signed multiply.
      assign prod   = Y_PROD_W'(din_reg) * Y_PROD_W'($signed({1'b0, g_reg}));
      assign scaled = prod >>> G_FRAC;
      // |scaled| <= 2^23, so narrowing to the output width loses nothing.
      assign y_next = W_IN_MODULE'(scaled);

      assign y_ext  = AWIDTH'(y_reg);
      assign mag    = y_reg[W_IN_MODULE-1] ? $unsigned(-y_ext) : $unsigned(y_ext);

      // Hold the raw sample from the strobe until it is scaled.
      always_ff @(posedge clk) begin
        if (rst) begin
          din_reg <= '0;
        end else if (s_chans.valid) begin
          din_reg <= din_in;
        end
      end

      // Scaled sample, which also serves as the held output value.
      always_ff @(posedge clk) begin
        if (rst) begin
          y_reg <= '0;
        end else if (vld_reg[0]) begin
          y_reg <= y_next;
        end
      end
    end
  endgenerate

  assign OutputI   = g_chan[0].y_reg;
  assign OutputQ   = g_chan[1].y_reg;
  assign Valid_Out = vld_reg[1];

  // L1 amplitude of the scaled pair. The sum is at most 2^24, well inside AWIDTH.
  assign a_next = g_chan[0].mag + g_chan[1].mag;

  // First-order IIR on the amplitude.
  logic signed [P_DIFF_W-1:0] p_diff;
  logic signed [P_PROD_W-1:0] p_prod;
  logic signed [P_PROD_W-1:0] p_step;
  logic signed [P_SUM_W-1:0]  p_sum;

  assign p_diff = $signed({1'b0, a_reg}) - $signed({1'b0, p_reg});
  assign p_prod = P_PROD_W'(p_diff) * P_PROD_W'($signed({1'b0, fc_reg[2]}));
  assign p_step = p_prod >>> FILTERWIDTH;
  assign p_sum  = P_SUM_W'($signed({1'b0, p_reg})) + P_SUM_W'(p_step);

  // Keep the filtered amplitude non-negative. Floor rounding could otherwise dip below 0.
  always_comb begin
    p_next = AWIDTH'(p_sum);
    if (p_sum[P_SUM_W-1]) begin
      p_next = '0;
    end
  end

  // Error against the reference, which is expressed in units of 256 LSBs.
  logic signed [E_WIDE_W-1:0] e_ref;
  logic signed [E_WIDE_W-1:0] e_wide;

  assign e_ref  = $signed(E_WIDE_W'({r_reg[3], {R_SHIFT{1'b0}}}));
  assign e_wide = e_ref - $signed({1'b0, p_reg});
  // P stays below 2^25, so the error always fits DWIDTH.
  assign e_next = DWIDTH'(e_wide);

  // Gain step from the error, scaled by the loop coefficient.
  logic signed [E_PROD_W-1:0] g_prod;
  logic signed [E_PROD_W-1:0] g_step;
  logic signed [G_SUM_W-1:0]  g_sum;

  assign g_prod = E_PROD_W'(e_reg) * E_PROD_W'($signed({1'b0, ec_reg[4]}));
  assign g_step = g_prod >>> E_SHIFT;
  assign g_sum  = G_SUM_W'($signed({1'b0, g_reg})) + G_SUM_W'(g_step);

  // Saturate the gain to its unsigned register range so that it never wraps.
  always_comb begin
    g_next = BWIDTH'(g_sum);
    if (g_sum[G_SUM_W-1]) begin
      g_next = '0;
    end else if (g_sum > G_SUM_MAX) begin
      g_next = G_MAX;
    end
  end

  // Amplitude, filter, error and gain registers. Each advances only for a sample at that stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      p_reg <= '0;
      e_reg <= '0;
      g_reg <= G_UNITY;
    end else begin
      if (vld_reg[1]) a_reg <= a_next;
      if (vld_reg[2]) p_reg <= p_next;
      if (vld_reg[3]) e_reg <= e_next;
      if (vld_reg[4]) g_reg <= g_next;
    end
  end

endmodule

// File: tb/tb_test_1.sv
// Self-checking bench for the AGC core.
// The reference model works per sample in arrival order. A sample captured on
// edge c is scaled by the gain after every update from samples captured at or
// before edge c-5. The P and G updates are applied sequentially, one per sample.
module tb_test_1;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [12:0]        fc;
  logic [12:0]        ec;
  logic [7:0]         r_lvl;
  logic               valid_out;
  logic signed [25:0] out_i;
  logic signed [25:0] out_q;

  test_1_if #(.W_IN(16)) bus ();

  test_1 dut (
    .clk                (clk),
    .rst                (rst),
    .s_chans            (bus),
    .Filter_Coefficient (fc),
    .Error_Coefficient  (ec),
    .R_level            (r_lvl),
    .Valid_Out          (valid_out),
    .OutputI            (out_i),
    .OutputQ            (out_q)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  longint g_hist[$];   // g_hist[m] = gain after m updates since reset
  longint cap_cyc[$];  // capture edge of every sample since reset
  longint p_m;
  bit     pend_v;
  longint pend_i, pend_q;
  bit     exp_v;
  longint exp_i, exp_q;
  bit     model_ready = 1'b0;

  function automatic longint mabs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    g_hist.delete();
    g_hist.push_back(1024);
    cap_cyc.delete();
    p_m    = 0;
    pend_v = 0;
  endtask

  task automatic model_capture(input longint i, input longint q, input longint f,
                               input longint e_c, input longint r);
    int     m = 0;
    longint g, yi, yq, a, e, gn;
    foreach (cap_cyc[k]) if (cap_cyc[k] <= cyc - 5) m++;
    g  = g_hist[m];
    yi = (i * g) >>> 10;
    yq = (q * g) >>> 10;
    a  = mabs(yi) + mabs(yq);
    p_m = p_m + (((a - p_m) * f) >>> 13);
    if (p_m < 0) p_m = 0;
    e  = r * 256 - p_m;
    gn = g_hist[g_hist.size() - 1] + ((e * e_c) >>> 19);
    if (gn < 0) gn = 0;
    if (gn > 262143) gn = 262143;
    g_hist.push_back(gn);
    cap_cyc.push_back(cyc);
    pend_v = 1;
    pend_i = yi;
    pend_q = yq;
  endtask

  // Model advances on every rising edge, using the inputs that were stable at that edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_reset();
        exp_v = 0;
        exp_i = 0;
        exp_q = 0;
        model_ready = 1'b1;
      end else begin
        exp_v = pend_v;
        if (pend_v) begin
          exp_i = pend_i;
          exp_q = pend_q;
        end
        pend_v = 0;
        if (bus.valid) model_capture(bus.dataI, bus.dataQ, fc, ec, r_lvl);
      end
    end
  end

  // Compare the DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ready) begin
        check("valid_out", valid_out, exp_v);
        check("out_i", out_i, exp_i);
        check("out_q", out_q, exp_q);
        if (exp_v) $display("txn edge=%0d out_i=%0d out_q=%0d", cyc, out_i, out_q);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present one sample, then read its outputs one edge after capture. After
  // capture, scramble the controls so that only the captured values should matter.
  task automatic send(input longint i, input longint q, input int f, input int e_c,
                      input int r, input int gap,
                      output longint oi, output longint oq, output bit ov);
    bus.dataI = 16'(i);
    bus.dataQ = 16'(q);
    fc        = 13'(f);
    ec        = 13'(e_c);
    r_lvl     = 8'(r);
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    fc        = 13'($urandom);
    ec        = 13'($urandom);
    r_lvl     = 8'($urandom);
    @(negedge clk);
    oi = out_i;
    oq = out_q;
    ov = valid_out;
    repeat (gap) @(negedge clk);
  endtask

  longint oi, oq, sum;
  bit     ov;
  int     ri, rq;

  initial begin
    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.dataI = '0;
    bus.dataQ = '0;
    fc        = '0;
    ec        = '0;
    r_lvl     = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", valid_out, 0);
    check("reset_out_i", out_i, 0);
    check("reset_out_q", out_q, 0);
    rst = 1'b0;

    // Unity path
    send(1000, -500, 0, 0, 0, 0, oi, oq, ov);
    check("unity_valid", ov, 1);
    check("unity_i", oi, 1000);
    check("unity_q", oq, -500);
    @(negedge clk);
    check("unity_pulse_end", valid_out, 0);
    repeat (38) @(negedge clk);

    // Frozen loop: the gain stays at unity
    for (int n = 0; n < 50; n++) begin
      ri = int'($urandom_range(65535)) - 32768;
      rq = int'($urandom_range(65535)) - 32768;
      send(ri, rq, 0, 0, int'($urandom_range(255)), 38, oi, oq, ov);
      check("frozen_i", oi, ri);
      check("frozen_q", oq, rq);
    end

    // Single gain step: e=25600 gives dG=200
    send(0, 0, 0, 4096, 100, 38, oi, oq, ov);
    send(1024, 0, 0, 0, 0, 38, oi, oq, ov);
    check("gain_step_i", oi, 1224);

    // Convergence from a clean state
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 500; n++) send(4096, 4096, 4096, 4096, 64, 38, oi, oq, ov);
    sum = mabs(oi) + mabs(oq);
    n_checks++;
    if (sum >= 16056 && sum <= 16712) n_pass++;
    else $display("FAIL converge_band: actual=%0d required=16384 within 2 percent", sum);

    // Reset on the edge right after capture: the sample is discarded
    bus.dataI = 1000;
    bus.dataQ = -500;
    fc = 0;
    ec = 0;
    r_lvl = 0;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid", valid_out, 0);
    check("rstmid_out_i", out_i, 0);
    check("rstmid_out_q", out_q, 0);
    // Valid and reset on the same edge: the sample is dropped
    bus.dataI = 777;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("same_edge_valid", valid_out, 0);
    send(1000, -500, 0, 0, 0, 5, oi, oq, ov);
    check("post_reset_i", oi, 1000);
    check("post_reset_q", oq, -500);

    // Saturation with close sample spacing
    for (int n = 0; n < 300; n++) begin
      ri = int'($urandom_range(65535)) - 32768;
      rq = int'($urandom_range(65535)) - 32768;
      send(ri, rq, 0, 8191, 255, int'($urandom_range(3)), oi, oq, ov);
    end
    repeat (8) @(negedge clk);
    send(-32768, 0, 0, 8191, 255, 5, oi, oq, ov);
    check("sat_out_i", oi, -8388576);
    check("sat_out_q", oq, 0);

    // Random back-to-back traffic with random controls and occasional resets
    for (int n = 0; n < 2000; n++) begin
      bus.valid = ($urandom_range(2) == 0);
      bus.dataI = 16'($urandom);
      bus.dataQ = 16'($urandom);
      fc        = 13'($urandom);
      ec        = 13'($urandom);
      r_lvl     = 8'($urandom);
      rst       = ($urandom_range(299) == 0);
      @(negedge clk);
    end
    bus.valid = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
